write_combine_buffer: RTL and testbench
=======================================

Name: write_combine_buffer

Overview:
Multi-slot write-combining buffer between the accelerator datapath and the CCI write-request channel. Sub-line word writes are merged into up to NUM_SLOTS open cache-line slots. A slot is issued as one full-line write when it fills, when it is evicted for capacity, or on flush. Direct full-line writes bypass the slots, and the block tracks outstanding writes until their responses return.

Parameters:
ADDR_LMT, 20, cache-line address width
MDATA, 14, request tag width
CACHE_WIDTH, 512, line width in bits
WORD_WIDTH, 32, merged word width; CACHE_WIDTH must be a multiple of it
NUM_SLOTS, 4, open line slots (power of 2, ≥2)
MAX_OUTSTANDING, 64, cap on issued-but-unacknowledged writes
Derived (localparam): WORDS=CACHE_WIDTH/WORD_WIDTH, WIDX=$clog2(WORDS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  leave IDLE
wr_en  in  1  word write strobe
wr_addr  in  ADDR_LMT+WIDX  word address: upper ADDR_LMT bits are the line, low WIDX bits are the word index
wr_data  in  WORD_WIDTH  word data
wr_direct  in  1  full-line write strobe (mutually exclusive with wr_en)
wr_line_data  in  CACHE_WIDTH  direct line data
wr_ready  out  1  a strobe asserted this cycle is accepted
flush  in  1  pulse: drain all slots and wait for all responses
flush_done  out  1  one-cycle pulse when a flush completes
wr_req_addr  out  ADDR_LMT  request line address
wr_req_mdata  out  MDATA  request tag
wr_req_data  out  CACHE_WIDTH  request data
wr_req_en  out  1  request valid (one cycle per request)
wr_req_almostfull  in  1  channel backpressure
wr_rsp0_valid  in  1  response channel 0
wr_rsp1_valid  in  1  response channel 1
outstanding  out  $clog2(MAX_OUTSTANDING+1)  unacknowledged write count
idle  out  1  no valid slots and outstanding==0

Behaviour:
- Reset: all wr_req_* outputs are 0, wr_ready=0 and flush_done=0. All slots are invalid, outstanding=0, the tag counter is 0, state is IDLE and idle=1.
- States:
  - IDLE → RUN on start.
  - RUN → FLUSH on flush.
  - FLUSH → RUN in the cycle after flush_done.
  - In IDLE, wr_ready=0 and all strobes are ignored.
- Request outputs are registered: a request chosen in cycle N is visible on wr_req_* in cycle N+1.
- At most one request is issued per cycle, and none while wr_req_almostfull=1 or outstanding==MAX_OUTSTANDING.
- Each issued request carries wr_req_mdata = tag counter, which then increments and wraps modulo 2^MDATA.
- Slot state: valid, line address, data, and a WORDS-bit mask. Unmasked words are 0 when the slot is issued. A freshly allocated slot has zero data and zero mask.
- Word write, hit (valid slot with the same line): wr_ready=1. The word is merged at index×WORD_WIDTH and its mask bit set; a rewrite of an already-masked word overwrites it.
- Word write, miss with a free slot: wr_ready=1. The lowest-index free slot is allocated.
- Word write, miss with no free slot: wr_ready=0. The oldest-allocated slot (FIFO age order) is issued when issue is permitted and freed. The write is accepted the next cycle.
- Full line: if a merge sets the last mask bit, that slot is issued in the same cycle and freed. If issue is blocked, wr_ready=0 for that write and nothing merges.
- Direct write: wr_ready=1 only when issue is permitted, and it issues wr_line_data at wr_addr's line. A valid slot for the same line is discarded, since the direct line supersedes it.
- Issue priority within a cycle: direct > full-line > capacity eviction > flush drain.
- FLUSH: wr_ready=0. One valid slot is issued per permitted cycle, lowest index first. When no slot is valid and outstanding==0, flush_done pulses for one cycle.
- Flush with nothing open and nothing outstanding: flush_done fires 1 cycle after flush.
- outstanding = +1 per issue, −1 per response valid. Simultaneous issue, rsp0 and rsp1 give a net change of −1.
- A response while outstanding==0 is ignored and the count saturates at 0.
- Reset mid-operation: all slots and outstanding state are discarded immediately; in-flight responses are ignored.

Test Plan:
1. WORD_WIDTH=32: 16 writes to line 5, indices 0..15 with data=index → exactly one wr_req_en, addr 5, data word i = i, mdata 0; outstanding 1, then 0 after rsp0.
2. Write idx 3 of lines 1,2,3,4, then line 6 (NUM_SLOTS=4) → wr_ready=0 for 1 cycle; line 1 issued with only word 3 nonzero; line 6 accepted the next cycle.
3. Open line 7 (idx 0 = 0xA), then direct write line 7 with all-ones data → a single request with all-ones data; slot freed and idle after the response.
4. wr_req_almostfull=1 while line 9 completes → wr_ready held 0 and no request; deassert → request issued and the write accepted.
5. Two open slots plus flush, rsp0 and rsp1 returned in the same cycle → 2 requests from the lower slot index first, then outstanding 2→0 and flush_done a single pulse.
6. Drive rst low mid-flush with 3 outstanding → outputs go to 0 at once and idle=1; responses after reset leave outstanding=0.

Source files
------------

// File: rtl/write_combine_buffer_if.sv
// Write-side and CCI-channel signal bundle for the write-combining buffer.
// The slave modport is the buffer; the master modport is the datapath/channel side.
interface write_combine_buffer_if #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int WORD_WIDTH  = 32
);
    localparam int WIDX = $clog2(CACHE_WIDTH / WORD_WIDTH);

    logic                     wrEn;
    logic [ADDR_LMT+WIDX-1:0] wrAddr;
    logic [WORD_WIDTH-1:0]    wrData;
    logic                     wrDirect;
    logic [CACHE_WIDTH-1:0]   wrLineData;
    logic                     wrReady;

    logic [ADDR_LMT-1:0]      wrReqAddr;
    logic [MDATA-1:0]         wrReqMdata;
    logic [CACHE_WIDTH-1:0]   wrReqData;
    logic                     wrReqEn;
    logic                     wrReqAlmostFull;
    logic                     wrRsp0Valid;
    logic                     wrRsp1Valid;

    modport master (
        output wrEn, wrAddr, wrData, wrDirect, wrLineData,
        output wrReqAlmostFull, wrRsp0Valid, wrRsp1Valid,
        input  wrReady, wrReqAddr, wrReqMdata, wrReqData, wrReqEn
    );

    modport slave (
        input  wrEn, wrAddr, wrData, wrDirect, wrLineData,
        input  wrReqAlmostFull, wrRsp0Valid, wrRsp1Valid,
        output wrReady, wrReqAddr, wrReqMdata, wrReqData, wrReqEn
    );
endinterface

// File: rtl/write_combine_buffer.sv
// Multi-slot write-combining buffer: merges word writes into open cache-line slots and
// issues full-line writes on fill, capacity eviction, flush or direct line writes.
module write_combine_buffer #(
    parameter int ADDR_LMT        = 20,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int WORD_WIDTH      = 32,
    parameter int NUM_SLOTS       = 4,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_start,
    input  logic                                   i_flush,
    output logic                                   o_flushDone,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding,
    output logic                                   o_idle,
    write_combine_buffer_if.slave                  bus
);
    localparam int WORDS = CACHE_WIDTH / WORD_WIDTH;
    localparam int WIDX  = $clog2(WORDS);
    localparam int SW    = $clog2(NUM_SLOTS);
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int DW    = $clog2(CACHE_WIDTH);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  r_state;
    state_t                  w_nextState;

    logic [NUM_SLOTS-1:0]    r_valid;
    logic [ADDR_LMT-1:0]     r_addr [NUM_SLOTS];
    logic [CACHE_WIDTH-1:0]  r_data [NUM_SLOTS];
    logic [WORDS-1:0]        r_mask [NUM_SLOTS];
    logic [SW-1:0]           r_age  [NUM_SLOTS];

    logic [MDATA-1:0]        r_tag;
    logic [OW-1:0]           r_outstanding;
    logic                    r_reqEn;
    logic [ADDR_LMT-1:0]     r_reqAddr;
    logic [MDATA-1:0]        r_reqMdata;
    logic [CACHE_WIDTH-1:0]  r_reqData;

    logic [ADDR_LMT-1:0]     w_line;
    logic [WIDX-1:0]         w_wordIdx;
    logic [DW-1:0]           w_wordBase;
    logic                    w_anyValid;
    logic                    w_canIssue;
    logic                    w_inRun;
    logic                    w_inFlush;
    logic                    w_flushDone;

    logic                    w_hit;
    logic [SW-1:0]           w_hitIdx;
    logic                    w_hasFree;
    logic [SW-1:0]           w_freeSlot;
    logic [SW-1:0]           w_lowIdx;
    logic [SW-1:0]           w_oldIdx;
    logic [SW-1:0]           w_oldAge;

    logic                    w_ready;
    logic                    w_issue;
    logic [ADDR_LMT-1:0]     w_issueAddr;
    logic [CACHE_WIDTH-1:0]  w_issueData;
    logic                    w_freeEn;
    logic [SW-1:0]           w_freeIdx;
    logic                    w_mergeEn;
    logic                    w_allocEn;
    logic [SW-1:0]           w_slotIdx;
    logic [CACHE_WIDTH-1:0]  w_mergeData;
    logic [WORDS-1:0]        w_mergeMask;

    logic [OW+1:0]           w_outInc;
    logic [OW+1:0]           w_outDec;
    logic [OW-1:0]           w_outNext;

    assign w_line     = bus.wrAddr[ADDR_LMT+WIDX-1:WIDX];
    assign w_wordIdx  = bus.wrAddr[WIDX-1:0];
    assign w_wordBase = DW'(w_wordIdx) * DW'(WORD_WIDTH);
    assign w_anyValid = |r_valid;
    assign w_canIssue = !bus.wrReqAlmostFull && (r_outstanding != OUT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_start)     w_nextState = RUN;
            RUN:     if (i_flush)     w_nextState = FLUSH;
            FLUSH:   if (w_flushDone) w_nextState = RUN;
            default:                  w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_inRun     = (r_state == RUN);
        w_inFlush   = (r_state == FLUSH);
        w_flushDone = w_inFlush && !w_anyValid && (r_outstanding == '0);
    end

    // Slot lookups; descending scan leaves the lowest matching index selected.
    always_comb begin
        w_hit      = 1'b0;
        w_hitIdx   = '0;
        w_hasFree  = 1'b0;
        w_freeSlot = '0;
        w_lowIdx   = '0;
        w_oldIdx   = '0;
        w_oldAge   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_addr[i] == w_line)) begin
                w_hit    = 1'b1;
                w_hitIdx = SW'(i);
            end
            if (!r_valid[i]) begin
                w_hasFree  = 1'b1;
                w_freeSlot = SW'(i);
            end
            if (r_valid[i]) begin
                w_lowIdx = SW'(i);
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_valid[i] && (r_age[i] >= w_oldAge)) begin
                w_oldAge = r_age[i];
                w_oldIdx = SW'(i);
            end
        end
    end

    // One issue decision per cycle: direct, then full-line, then eviction, then drain.
    always_comb begin
        w_ready     = 1'b0;
        w_issue     = 1'b0;
        w_issueAddr = '0;
        w_issueData = '0;
        w_freeEn    = 1'b0;
        w_freeIdx   = '0;
        w_mergeEn   = 1'b0;
        w_allocEn   = 1'b0;
        w_slotIdx   = w_hit ? w_hitIdx : w_freeSlot;
        w_mergeData = w_hit ? r_data[w_hitIdx] : '0;
        w_mergeMask = w_hit ? r_mask[w_hitIdx] : '0;
        w_mergeData[w_wordBase +: WORD_WIDTH] = bus.wrData;
        w_mergeMask[w_wordIdx] = 1'b1;

        if (w_inRun && bus.wrDirect) begin
            if (w_canIssue) begin
                w_ready     = 1'b1;
                w_issue     = 1'b1;
                w_issueAddr = w_line;
                w_issueData = bus.wrLineData;
                w_freeEn    = w_hit;
                w_freeIdx   = w_hitIdx;
            end
        end else if (w_inRun && bus.wrEn) begin
            if (w_hit || w_hasFree) begin
                if (&w_mergeMask) begin
                    if (w_canIssue) begin
                        w_ready     = 1'b1;
                        w_issue     = 1'b1;
                        w_issueAddr = w_line;
                        w_issueData = w_mergeData;
                        w_freeEn    = w_hit;
                        w_freeIdx   = w_hitIdx;
                    end
                end else begin
                    w_ready   = 1'b1;
                    w_mergeEn = 1'b1;
                    w_allocEn = !w_hit;
                end
            end else if (w_canIssue) begin
                w_issue     = 1'b1;
                w_issueAddr = r_addr[w_oldIdx];
                w_issueData = r_data[w_oldIdx];
                w_freeEn    = 1'b1;
                w_freeIdx   = w_oldIdx;
            end
        end else if (w_inFlush && w_anyValid && w_canIssue) begin
            w_issue     = 1'b1;
            w_issueAddr = r_addr[w_lowIdx];
            w_issueData = r_data[w_lowIdx];
            w_freeEn    = 1'b1;
            w_freeIdx   = w_lowIdx;
        end
    end

    // Age is the rank among valid slots (0 = newest); the oldest has the largest rank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_mask[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            if (w_freeEn) begin
                r_valid[w_freeIdx] <= 1'b0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (r_valid[i] && (r_age[i] > r_age[w_freeIdx])) begin
                        r_age[i] <= r_age[i] - SW'(1);
                    end
                end
            end
            if (w_mergeEn) begin
                r_data[w_slotIdx] <= w_mergeData;
                r_mask[w_slotIdx] <= w_mergeMask;
                if (w_allocEn) begin
                    r_valid[w_slotIdx] <= 1'b1;
                    r_addr[w_slotIdx]  <= w_line;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (r_valid[i]) begin
                            r_age[i] <= r_age[i] + SW'(1);
                        end
                    end
                    r_age[w_slotIdx] <= '0;
                end
            end
        end
    end

    // Responses beyond the outstanding count are dropped so the count floors at zero.
    always_comb begin
        w_outInc  = (OW+2)'(r_outstanding) + (OW+2)'(w_issue);
        w_outDec  = (OW+2)'(bus.wrRsp0Valid) + (OW+2)'(bus.wrRsp1Valid);
        w_outNext = (w_outInc > w_outDec) ? OW'(w_outInc - w_outDec) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reqEn       <= 1'b0;
            r_reqAddr     <= '0;
            r_reqMdata    <= '0;
            r_reqData     <= '0;
            r_tag         <= '0;
            r_outstanding <= '0;
        end else begin
            r_reqEn       <= w_issue;
            r_outstanding <= w_outNext;
            if (w_issue) begin
                r_reqAddr  <= w_issueAddr;
                r_reqData  <= w_issueData;
                r_reqMdata <= r_tag;
                r_tag      <= r_tag + MDATA'(1);
            end
        end
    end

    assign bus.wrReady    = w_ready;
    assign bus.wrReqEn    = r_reqEn;
    assign bus.wrReqAddr  = r_reqAddr;
    assign bus.wrReqMdata = r_reqMdata;
    assign bus.wrReqData  = r_reqData;
    assign o_flushDone    = w_flushDone;
    assign o_outstanding  = r_outstanding;
    assign o_idle         = !w_anyValid && (r_outstanding == '0);
endmodule

// File: tb/tb_write_combine_buffer.sv
// Directed bench for write_combine_buffer: merging, eviction, direct writes,
// backpressure, flush draining and reset while writes are in flight.
module tb_write_combine_buffer;
    typedef struct {
        logic [19:0]  addr;
        logic [13:0]  mdata;
        logic [511:0] data;
    } req_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       flush;
    logic       flushDone;
    logic [6:0] outstanding;
    logic       idle;

    int   checkCount = 0;
    int   failCount = 0;
    int   flushDoneCount = 0;
    req_t reqQ[$];

    write_combine_buffer_if bus ();

    write_combine_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_flush      (flush),
        .o_flushDone  (flushDone),
        .o_outstanding(outstanding),
        .o_idle       (idle),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wrReqEn) reqQ.push_back('{bus.wrReqAddr, bus.wrReqMdata, bus.wrReqData});
        if (flushDone) flushDoneCount++;
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one word write and holds it until accepted (bounded).
    task automatic applyStimulus(input logic [19:0] line, input logic [3:0] idx,
                                 input logic [31:0] data, output int stalls);
        bus.wrEn   = 1'b1;
        bus.wrAddr = {line, idx};
        bus.wrData = data;
        stalls     = 0;
        #1;
        while (!bus.wrReady && stalls < 20) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        checkOutput("wrAccept", 512'(bus.wrReady), 512'(1));
        @(posedge clk);
        #1;
        bus.wrEn = 1'b0;
    endtask

    task automatic sendRsp(input logic r0, input logic r1);
        bus.wrRsp0Valid = r0;
        bus.wrRsp1Valid = r1;
        @(posedge clk);
        #1;
        bus.wrRsp0Valid = 1'b0;
        bus.wrRsp1Valid = 1'b0;
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls;
        int base;
        int fdBase;
        logic [511:0] expData;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        bus.wrEn = 1'b0;
        bus.wrAddr = '0;
        bus.wrData = '0;
        bus.wrDirect = 1'b0;
        bus.wrLineData = '0;
        bus.wrReqAlmostFull = 1'b0;
        bus.wrRsp0Valid = 1'b0;
        bus.wrRsp1Valid = 1'b0;

        #3;
        checkOutput("rstReqEn", 512'(bus.wrReqEn), 512'(0));
        checkOutput("rstReady", 512'(bus.wrReady), 512'(0));
        checkOutput("rstFlushDone", 512'(flushDone), 512'(0));
        checkOutput("rstOutstanding", 512'(outstanding), 512'(0));
        checkOutput("rstIdle", 512'(idle), 512'(1));
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // IDLE ignores strobes
        bus.wrEn = 1'b1;
        bus.wrAddr = {20'd5, 4'd0};
        #1;
        checkOutput("idleReady", 512'(bus.wrReady), 512'(0));
        @(posedge clk);
        #1;
        bus.wrEn = 1'b0;
        checkOutput("idleNoAlloc", 512'(idle), 512'(1));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Test 1: fill line 5 word by word
        base = reqQ.size();
        for (int i = 0; i < 16; i++) applyStimulus(20'd5, 4'(i), 32'(i), stalls);
        checkOutput("t1Outstanding", 512'(outstanding), 512'(1));
        waitCycles(1);
        checkOutput("t1ReqCount", 512'(reqQ.size() - base), 512'(1));
        expData = '0;
        for (int i = 0; i < 16; i++) expData[i*32 +: 32] = 32'(i);
        checkOutput("t1Addr", 512'(reqQ[base].addr), 512'(5));
        checkOutput("t1Mdata", 512'(reqQ[base].mdata), 512'(0));
        checkOutput("t1Data", reqQ[base].data, expData);
        sendRsp(1'b1, 1'b0);
        checkOutput("t1OutstandingRsp", 512'(outstanding), 512'(0));
        checkOutput("t1Idle", 512'(idle), 512'(1));

        // Test 2: capacity eviction of oldest slot, then flush drains lowest index first
        base = reqQ.size();
        for (int i = 1; i <= 4; i++) applyStimulus(20'(i), 4'd3, 32'(i * 'h11), stalls);
        checkOutput("t2NoReqYet", 512'(reqQ.size() - base), 512'(0));
        applyStimulus(20'd6, 4'd3, 32'h66, stalls);
        checkOutput("t2Stall", 512'(stalls), 512'(1));
        waitCycles(1);
        checkOutput("t2ReqCount", 512'(reqQ.size() - base), 512'(1));
        checkOutput("t2EvictAddr", 512'(reqQ[base].addr), 512'(1));
        checkOutput("t2EvictMdata", 512'(reqQ[base].mdata), 512'(1));
        checkOutput("t2EvictData", reqQ[base].data, 512'(32'h11) << 96);
        fdBase = flushDoneCount;
        pulseFlush();
        waitCycles(5);
        checkOutput("t2FlushCount", 512'(reqQ.size() - base), 512'(5));
        checkOutput("t2Drain0Addr", 512'(reqQ[base+1].addr), 512'(6));
        checkOutput("t2Drain0Data", reqQ[base+1].data, 512'(32'h66) << 96);
        checkOutput("t2Drain1Addr", 512'(reqQ[base+2].addr), 512'(2));
        checkOutput("t2Drain2Addr", 512'(reqQ[base+3].addr), 512'(3));
        checkOutput("t2Drain3Addr", 512'(reqQ[base+4].addr), 512'(4));
        checkOutput("t2Drain3Mdata", 512'(reqQ[base+4].mdata), 512'(5));
        checkOutput("t2Outstanding", 512'(outstanding), 512'(5));
        checkOutput("t2NoDoneYet", 512'(flushDoneCount - fdBase), 512'(0));
        sendRsp(1'b1, 1'b1);
        sendRsp(1'b1, 1'b1);
        sendRsp(1'b1, 1'b0);
        checkOutput("t2OutstandingZero", 512'(outstanding), 512'(0));
        waitCycles(3);
        checkOutput("t2FlushDone", 512'(flushDoneCount - fdBase), 512'(1));

        // Test 3: direct write supersedes an open slot for the same line
        base = reqQ.size();
        applyStimulus(20'd7, 4'd0, 32'hA, stalls);
        bus.wrDirect = 1'b1;
        bus.wrAddr = {20'd7, 4'd0};
        bus.wrLineData = '1;
        #1;
        checkOutput("t3DirectReady", 512'(bus.wrReady), 512'(1));
        @(posedge clk);
        #1;
        bus.wrDirect = 1'b0;
        checkOutput("t3NotIdle", 512'(idle), 512'(0));
        waitCycles(2);
        checkOutput("t3ReqCount", 512'(reqQ.size() - base), 512'(1));
        checkOutput("t3Addr", 512'(reqQ[base].addr), 512'(7));
        checkOutput("t3Mdata", 512'(reqQ[base].mdata), 512'(6));
        checkOutput("t3Data", reqQ[base].data, {512{1'b1}});
        sendRsp(1'b0, 1'b1);
        checkOutput("t3Idle", 512'(idle), 512'(1));

        // Test 4: almost-full blocks the completing write of line 9
        base = reqQ.size();
        expData = '0;
        for (int i = 0; i < 16; i++) expData[i*32 +: 32] = 32'('h900 + i);
        for (int i = 0; i < 15; i++) applyStimulus(20'd9, 4'(i), 32'('h900 + i), stalls);
        bus.wrReqAlmostFull = 1'b1;
        bus.wrEn = 1'b1;
        bus.wrAddr = {20'd9, 4'd15};
        bus.wrData = 32'h90F;
        #1;
        checkOutput("t4BlockedReady", 512'(bus.wrReady), 512'(0));
        waitCycles(2);
        checkOutput("t4StillBlocked", 512'(bus.wrReady), 512'(0));
        checkOutput("t4NoReq", 512'(reqQ.size() - base), 512'(0));
        bus.wrReqAlmostFull = 1'b0;
        #1;
        checkOutput("t4Ready", 512'(bus.wrReady), 512'(1));
        @(posedge clk);
        #1;
        bus.wrEn = 1'b0;
        checkOutput("t4ReqEn", 512'(bus.wrReqEn), 512'(1));
        waitCycles(1);
        checkOutput("t4ReqCount", 512'(reqQ.size() - base), 512'(1));
        checkOutput("t4Mdata", 512'(reqQ[base].mdata), 512'(7));
        checkOutput("t4Data", reqQ[base].data, expData);
        sendRsp(1'b1, 1'b0);

        // Test 5: flush of two slots, dual response in one cycle
        base = reqQ.size();
        applyStimulus(20'h10, 4'd1, 32'hB1, stalls);
        applyStimulus(20'h11, 4'd2, 32'hB2, stalls);
        fdBase = flushDoneCount;
        pulseFlush();
        waitCycles(3);
        checkOutput("t5ReqCount", 512'(reqQ.size() - base), 512'(2));
        checkOutput("t5FirstAddr", 512'(reqQ[base].addr), 512'(20'h10));
        checkOutput("t5FirstMdata", 512'(reqQ[base].mdata), 512'(8));
        checkOutput("t5FirstData", reqQ[base].data, 512'(32'hB1) << 32);
        checkOutput("t5SecondAddr", 512'(reqQ[base+1].addr), 512'(20'h11));
        checkOutput("t5SecondData", reqQ[base+1].data, 512'(32'hB2) << 64);
        checkOutput("t5Outstanding2", 512'(outstanding), 512'(2));
        sendRsp(1'b1, 1'b1);
        checkOutput("t5Outstanding0", 512'(outstanding), 512'(0));
        waitCycles(3);
        checkOutput("t5DonePulses", 512'(flushDoneCount - fdBase), 512'(1));
        checkOutput("t5Idle", 512'(idle), 512'(1));

        // Empty flush completes one cycle later
        pulseFlush();
        checkOutput("emptyFlushDone", 512'(flushDone), 512'(1));
        waitCycles(1);
        checkOutput("emptyFlushDoneOff", 512'(flushDone), 512'(0));

        // Test 6: reset mid-flush with three writes outstanding
        for (int i = 0; i < 3; i++) applyStimulus(20'(32 + i), 4'd0, 32'(i + 1), stalls);
        pulseFlush();
        waitCycles(3);
        checkOutput("t6Outstanding3", 512'(outstanding), 512'(3));
        checkOutput("t6ReqEnBefore", 512'(bus.wrReqEn), 512'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("t6ReqEnReset", 512'(bus.wrReqEn), 512'(0));
        checkOutput("t6ReqAddrReset", 512'(bus.wrReqAddr), 512'(0));
        checkOutput("t6OutstandingReset", 512'(outstanding), 512'(0));
        checkOutput("t6IdleReset", 512'(idle), 512'(1));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sendRsp(1'b1, 1'b1);
        checkOutput("t6OutstandingAfterRsp", 512'(outstanding), 512'(0));
        checkOutput("t6IdleAfterRsp", 512'(idle), 512'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
